// File: rtl/mem_sram_ctrl_pkg.sv
// Shared MEM-stage definitions: SRAM controller FSM states and default base address.
// Also imported by the MEM-stage register and the hazard unit.
package mem_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        DONE
    } sram_state_t;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_phase_counter.sv
// Counts 0..WAIT_CYCLES-1 while enabled; last flags the final cycle of a phase.
// Wraps to 0 after last so back-to-back phases each get a full count.
module sram_phase_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic last
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign last = en && (cnt == CW'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: 32-bit loads/stores as two half-word accesses to a
// 16-bit asynchronous SRAM, freezing the pipeline while an access is in flight.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_enable,
    input  logic               mem_write_enable,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    sram_state_t        state;
    logic [SRAM_AW-2:0] wa;
    logic [SRAM_AW-2:0] wa_q;
    logic [15:0]        data_hi_q;
    logic               req;
    logic               in_phase;
    logic               last;

    assign req      = mem_read_enable | mem_write_enable;
    assign in_phase = state inside {WR_LO, WR_HI, RD_LO, RD_HI};
    assign ready    = (state == DONE) | ((state == IDLE) & ~req);
    assign freeze   = req & ~ready;

    // Modulo-2^32 offset, word index truncated to the SRAM word space.
    assign wa = (SRAM_AW-1)'((alu_out - BASE_ADDR) >> 2);

    sram_phase_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (in_phase),
        .clear(~in_phase),
        .last (last)
    );

    // Word address and upper store half are latched at accept so the
    // second phase is unaffected if the pipeline drops its request early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdata       <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            wa_q        <= '0;
            data_hi_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_write_enable) begin
                        state       <= WR_LO;
                        wa_q        <= wa;
                        data_hi_q   <= Val_Rm[31:16];
                        sram_addr   <= {wa, 1'b0};
                        sram_dq_out <= Val_Rm[15:0];
                        sram_dq_oe  <= 1'b1;
                        sram_we_n   <= 1'b0;
                    end else if (mem_read_enable) begin
                        state     <= RD_LO;
                        wa_q      <= wa;
                        sram_addr <= {wa, 1'b0};
                    end
                end
                WR_LO: begin
                    if (last) begin
                        state       <= WR_HI;
                        sram_addr   <= {wa_q, 1'b1};
                        sram_dq_out <= data_hi_q;
                    end
                end
                WR_HI: begin
                    if (last) begin
                        state      <= DONE;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end
                end
                RD_LO: begin
                    if (last) begin
                        state       <= RD_HI;
                        rdata[15:0] <= sram_dq_in;
                        sram_addr   <= {wa_q, 1'b1};
                    end
                end
                RD_HI: begin
                    if (last) begin
                        state        <= DONE;
                        rdata[31:16] <= sram_dq_in;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Memory-stage SRAM controller sitting directly downstream of the execute stage. It takes the execute stage's ALU result as a byte address and the Rm operand as store data. It then performs 32-bit loads and stores against an external 16-bit asynchronous SRAM as two half-word transfers. While an access is in flight it stalls the pipeline through `freeze`.

## Interface
- `WAIT_CYCLES`, default 2: clock cycles each half-word SRAM phase is held (≥1).
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, default 18: SRAM half-word address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read_enable` in 1: load request; held by the pipeline until `ready`.
- `mem_write_enable` in 1: store request; held by the pipeline until `ready`.
- `alu_out` in 32: byte address from the execute stage.
- `Val_Rm` in 32: store data.
- `rdata` out 32: last completed load word.
- `ready` out 1: access complete, or no access requested.
- `freeze` out 1: `(mem_read_enable | mem_write_enable) & ~ready`; stalls the upstream stages.
- `sram_addr` out SRAM_AW: half-word address.
- `sram_dq_out` out 16: write data driven to the SRAM.
- `sram_dq_oe` out 1: tristate enable for `sram_dq_out` (pad logic is outside this block).
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_we_n` out 1: active-low write strobe.

## Operation
- Word address `wa = (alu_out - BASE_ADDR) >> 2`, truncated to SRAM_AW-1 bits.
  - Low half-word at `{wa, 1'b0}`, high half-word at `{wa, 1'b1}`.
  - `alu_out[1:0]` is ignored.
- Address wrap: the subtraction is modulo 2^32, and the result is then truncated. There is no range check.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
  - IDLE:
    - `mem_write_enable` → WR_LO.
    - Otherwise `mem_read_enable` → RD_LO.
    - Otherwise stay.
    - Write has priority if both are asserted.
  - WR_LO: drive `sram_addr` = low half-word address, `sram_dq_out` = `Val_Rm[15:0]`, `sram_dq_oe` = 1, `sram_we_n` = 0 for WAIT_CYCLES cycles, then → WR_HI.
  - WR_HI: same as WR_LO with the high half-word address and `Val_Rm[31:16]`, then → DONE.
  - RD_LO: drive `sram_addr` = low half-word address, `sram_we_n` = 1, `sram_dq_oe` = 0. On the last cycle of the phase, capture `sram_dq_in` into `rdata[15:0]`, then → RD_HI.
  - RD_HI: same as RD_LO with the high half-word address, capturing into `rdata[31:16]`, then → DONE.
  - DONE: `ready` = 1 for exactly one cycle, `sram_we_n` = 1, `sram_dq_oe` = 0, then → IDLE unconditionally.
- Phase counter: counts 0..WAIT_CYCLES-1 within each phase and clears on every phase transition.
- `ready` = DONE, or (IDLE and no request). It is combinational from state and inputs.
- `rdata`: the low half is updated at the end of RD_LO and the high half at the end of RD_HI. It is stable from DONE until the next read's RD_LO capture. Writes never change it.
- A request whose enables drop mid-access is still completed (protocol violation, but no hang).

## Timing
- Reset values: state IDLE, counter 0, `rdata` 0, `sram_we_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `sram_dq_out` 0.
- `ready` is 1 after reset when there is no request.
- Load or store latency: a request first seen in IDLE at cycle 0 gives `ready` high in cycle 2·WAIT_CYCLES+1.
  - With WAIT_CYCLES=2, that is cycle 5.
  - `freeze` is high in cycles 0..2·WAIT_CYCLES.
- Back-to-back accesses: the pipeline advances at the DONE edge, and the next request is accepted from IDLE one cycle later. No transaction overlap.
- `sram_addr`, `sram_dq_out` and `sram_we_n` are stable for the whole phase. `sram_we_n` returns high for at least one cycle (DONE) between words.
- Reset mid-access: the next edge returns to IDLE with `sram_we_n` = 1 and the partial write is abandoned. `rdata` is cleared to 0.

## Structure
- Shared package: FSM state enum and the `BASE_ADDR` default constant, reused by the MEM-stage register and the hazard unit.
- One sub-module, `sram_phase_counter`: WAIT_CYCLES-parameterised counter with `clear` and `last` outputs.

## Test plan
- Store `alu_out`=1024, `Val_Rm`=0xDEADBEEF, WAIT_CYCLES=2 → `sram_addr` 0 with data 0xBEEF for 2 cycles, then `sram_addr` 1 with data 0xDEAD for 2 cycles; `ready` in cycle 5; `freeze` high in cycles 0–4.
- Load `alu_out`=1032, SRAM model returns 0x5678 at address 4 and 0x1234 at address 5 → `rdata`=0x12345678 at DONE; `sram_we_n` stays 1 throughout.
- Both enables high → write sequence only; `rdata` unchanged.
- No enables for 10 cycles → `ready`=1, `freeze`=0, SRAM bus idle.
- Reset asserted during WR_HI → IDLE next cycle; `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0.
- Load immediately followed by a store → second access starts the cycle after DONE; address wrap case `alu_out`=0 maps to `wa` = (2^32-1024)>>2, truncated.
